ex_stage: RTL and testbench
===========================

EX_STAGE -- requirements
Module: ex_stage

Interface
REQ-001 SHALL have parameter ZERO_REG, default 0, register index that is never forwarded.
REQ-002 SHALL have port clock  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  async, active-low reset.
REQ-004 SHALL have port idex_reg  input  121  packed ID/EX word.
REQ-005 SHALL have port stall  input  1  hold EX/MEM register.
REQ-006 SHALL have port flush  input  1  load a bubble into EX/MEM.
REQ-007 SHALL have port fw1_we/fw1_wa/fw1_dat  input  1/5/32  EX/MEM writeback tap.
REQ-008 SHALL have port fw2_we/fw2_wa/fw2_dat  input  1/5/32  MEM/WB writeback tap.
REQ-009 SHALL have port exmem_reg  output  75  packed EX/MEM word.
REQ-010 SHALL have port br_taken  output  1  registered brnch AND zero.

Function
REQ-011 SHALL unpack idex_reg as: reg_wr[0], alu_src[1], mem_wr[2], mem_to_rgs[3], mem_rd[4], brnch[5], alu_op[9:6], rdb[41:10], rda[73:42], im_gen[105:74], wa[110:106], rb[115:111], ra[120:116].
REQ-012 SHALL pack exmem_reg as: reg_wr[0], mem_to_rgs[1], mem_rd[2], mem_wr[3], brnch[4], zero[5], wa[10:6], wdat[42:11], alu_res[74:43].
REQ-013 SHALL compute operand A = fwd(ra, rda) and store data wdat = fwd(rb, rdb).
REQ-014 SHALL select operand B = im_gen when alu_src=1, else fwd(rb, rdb).
REQ-015 fwd(r,d) SHALL return fw1_dat if fw1_we and fw1_wa==r and r!=ZERO_REG, else fw2_dat on the same test for fw2, else d; fw1 wins when both match.
REQ-016 SHALL use alu_op encoding 0000 AND, 0001 OR, 0010 ADD, 0011 XOR, 0110 SUB, 0111 SLT (signed, result 0/1), 1000 SLL, 1001 SRL, 1010 SRA, 1100 NOR; shift amount B[4:0]; all other codes give 0.
REQ-017 ADD/SUB SHALL wrap modulo 2^32; no overflow flag.
REQ-018 zero SHALL be 1 when the 32-bit ALU result equals 0.
REQ-019 SHALL register exmem_reg and br_taken on the rising clock edge; latency from idex_reg to exmem_reg is 1 cycle.
REQ-020 SHALL hold exmem_reg and br_taken unchanged when stall=1 and flush=0.
REQ-021 SHALL, when flush=1, load bits [5:0] of exmem_reg and br_taken with 0; data fields are don't-care. flush has priority over stall.
REQ-022 SHALL capture forwarding inputs in the same cycle as idex_reg, with no internal bypass storage.

Reset
REQ-023 SHALL clear exmem_reg to 75'b0 and br_taken to 0 immediately while reset=0, independent of clock.
REQ-024 SHALL resume normal capture on the first rising edge after reset deasserts; reset asserted mid-stall or mid-flush overrides both.

Configuration
REQ-025 With macro EX_FWD_EN defined, forwarding per REQ-015 SHALL be compiled in.
REQ-026 Without EX_FWD_EN, fwd(r,d) SHALL return d; fw* ports remain present and are ignored.

Structure
REQ-027 A shared package SHALL hold the alu_op codes, the IDEX/EXMEM field offsets and widths (121, 75), and ZERO_REG's default.
REQ-028 The ALU SHALL be one combinational sub-module, ex_alu (a, b, alu_op -> res, zero); forwarding muxes and the register stay in ex_stage.

Verification
REQ-029 ADD, no hazards: rda=5, im_gen=7, alu_src=1, alu_op=0010, wa=3, reg_wr=1 -> next cycle alu_res=12, wa=3, reg_wr=1, zero=0.
REQ-030 Forward priority: ra=4, rda=1, fw1(we=1,wa=4,dat=10), fw2(we=1,wa=4,dat=20), alu_src=0, rb=0, rdb=0, ADD -> alu_res=10; fw1_we=0 -> 20; ra=0 with matches -> rda used.
REQ-031 Branch: rda=9, rdb=9, SUB, brnch=1 -> zero=1, br_taken=1; rdb=8 -> br_taken=0.
REQ-032 Stall then flush: stall=1 for 3 cycles with changing idex_reg -> exmem_reg constant; stall=1 and flush=1 -> exmem_reg[5:0]=0, br_taken=0.
REQ-033 Shifts and SLT: A=0x80000000, B=4, SRA -> 0xF8000000, SRL -> 0x08000000; A=-1, B=1, SLT -> 1; alu_op=1111 -> 0.
REQ-034 Async reset: assert reset=0 between clock edges with nonzero exmem_reg -> exmem_reg=0 immediately; with EX_FWD_EN undefined, rerun REQ-030 -> alu_res=1.

Source files
------------

// File: rtl/ex_stage_pkg.sv
// Shared definitions for the execute stage: ALU opcodes, pipeline word layouts and widths.
package ex_stage_pkg;

    localparam int IDEX_W  = 121;
    localparam int EXMEM_W = 75;

    localparam logic [4:0] ZERO_REG_DEFAULT = 5'd0;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;
    localparam logic [3:0] ALU_SLL = 4'b1000;
    localparam logic [3:0] ALU_SRL = 4'b1001;
    localparam logic [3:0] ALU_SRA = 4'b1010;
    localparam logic [3:0] ALU_NOR = 4'b1100;

    // ID/EX field offsets (LSB) and widths
    localparam int IDEX_REG_WR_OFF     = 0;
    localparam int IDEX_ALU_SRC_OFF    = 1;
    localparam int IDEX_MEM_WR_OFF     = 2;
    localparam int IDEX_MEM_TO_RGS_OFF = 3;
    localparam int IDEX_MEM_RD_OFF     = 4;
    localparam int IDEX_BRNCH_OFF      = 5;
    localparam int IDEX_ALU_OP_OFF     = 6;
    localparam int IDEX_ALU_OP_W       = 4;
    localparam int IDEX_RDB_OFF        = 10;
    localparam int IDEX_RDA_OFF        = 42;
    localparam int IDEX_IM_GEN_OFF     = 74;
    localparam int IDEX_WA_OFF         = 106;
    localparam int IDEX_RB_OFF         = 111;
    localparam int IDEX_RA_OFF         = 116;
    localparam int DATA_W              = 32;
    localparam int REG_IDX_W           = 5;

    // EX/MEM field offsets (LSB)
    localparam int EXMEM_REG_WR_OFF     = 0;
    localparam int EXMEM_MEM_TO_RGS_OFF = 1;
    localparam int EXMEM_MEM_RD_OFF     = 2;
    localparam int EXMEM_MEM_WR_OFF     = 3;
    localparam int EXMEM_BRNCH_OFF      = 4;
    localparam int EXMEM_ZERO_OFF       = 5;
    localparam int EXMEM_CTRL_W         = 6;
    localparam int EXMEM_WA_OFF         = 6;
    localparam int EXMEM_WDAT_OFF       = 11;
    localparam int EXMEM_ALU_RES_OFF    = 43;

    // Struct members are listed MSB first so they overlay the offsets above.
    typedef struct packed {
        logic [4:0]  ra;
        logic [4:0]  rb;
        logic [4:0]  wa;
        logic [31:0] im_gen;
        logic [31:0] rda;
        logic [31:0] rdb;
        logic [3:0]  alu_op;
        logic        brnch;
        logic        mem_rd;
        logic        mem_to_rgs;
        logic        mem_wr;
        logic        alu_src;
        logic        reg_wr;
    } idex_t;

    typedef struct packed {
        logic [31:0] alu_res;
        logic [31:0] wdat;
        logic [4:0]  wa;
        logic        zero;
        logic        brnch;
        logic        mem_wr;
        logic        mem_rd;
        logic        mem_to_rgs;
        logic        reg_wr;
    } exmem_t;

endpackage

// File: rtl/ex_alu.sv
// Combinational 32-bit ALU for the execute stage; unknown opcodes yield 0.
module ex_alu
    import ex_stage_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic [3:0]  alu_op,
    output logic [31:0] res,
    output logic        zero
);

    logic [4:0] shamt;
    assign shamt = b[4:0];

    always_comb begin
        res = 32'd0;
        case (alu_op)
            ALU_AND: res = a & b;
            ALU_OR:  res = a | b;
            ALU_ADD: res = a + b;
            ALU_XOR: res = a ^ b;
            ALU_SUB: res = a - b;
            ALU_SLT: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
            ALU_SLL: res = a << shamt;
            ALU_SRL: res = a >> shamt;
            ALU_SRA: res = $unsigned($signed(a) >>> shamt);
            ALU_NOR: res = ~(a | b);
            default: res = 32'd0;
        endcase
    end

    assign zero = (res == 32'd0);

endmodule

// File: rtl/ex_stage.sv
// Execute stage: operand forwarding, ALU and the EX/MEM pipeline register.
// Forwarding from the fw1/fw2 taps is compiled in only when EX_FWD_EN is defined.
module ex_stage
    import ex_stage_pkg::*;
#(
    parameter logic [4:0] ZERO_REG = ZERO_REG_DEFAULT
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic [IDEX_W-1:0]    idex_reg,
    input  logic                 stall,
    input  logic                 flush,
    input  logic                 fw1_we,
    input  logic [4:0]           fw1_wa,
    input  logic [31:0]          fw1_dat,
    input  logic                 fw2_we,
    input  logic [4:0]           fw2_wa,
    input  logic [31:0]          fw2_dat,
    output logic [EXMEM_W-1:0]   exmem_reg,
    output logic                 br_taken
);

    idex_t       idex;
    exmem_t      exmem_next;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic [31:0] rb_val;
    logic [31:0] alu_res;
    logic        alu_zero;

    assign idex = idex_t'(idex_reg);

`ifdef EX_FWD_EN
    // The older MEM/WB value is only used when the younger EX/MEM tap misses.
    function automatic logic [31:0] fwd(
        input logic [4:0]  r,
        input logic [31:0] d,
        input logic        we1,
        input logic [4:0]  wa1,
        input logic [31:0] dat1,
        input logic        we2,
        input logic [4:0]  wa2,
        input logic [31:0] dat2
    );
        if (we1 && (wa1 == r) && (r != ZERO_REG))
            return dat1;
        else if (we2 && (wa2 == r) && (r != ZERO_REG))
            return dat2;
        else
            return d;
    endfunction

    assign op_a   = fwd(idex.ra, idex.rda, fw1_we, fw1_wa, fw1_dat, fw2_we, fw2_wa, fw2_dat);
    assign rb_val = fwd(idex.rb, idex.rdb, fw1_we, fw1_wa, fw1_dat, fw2_we, fw2_wa, fw2_dat);
`else
    logic unused_fw;
    assign unused_fw = ^{fw1_we, fw1_wa, fw1_dat, fw2_we, fw2_wa, fw2_dat, ZERO_REG};
    assign op_a      = idex.rda;
    assign rb_val    = idex.rdb;
`endif

    assign op_b = idex.alu_src ? idex.im_gen : rb_val;

    ex_alu u_alu (
        .a      (op_a),
        .b      (op_b),
        .alu_op (idex.alu_op),
        .res    (alu_res),
        .zero   (alu_zero)
    );

    always_comb begin
        exmem_next            = '0;
        exmem_next.alu_res    = alu_res;
        exmem_next.wdat       = rb_val;
        exmem_next.wa         = idex.wa;
        exmem_next.zero       = alu_zero;
        exmem_next.brnch      = idex.brnch;
        exmem_next.mem_wr     = idex.mem_wr;
        exmem_next.mem_rd     = idex.mem_rd;
        exmem_next.mem_to_rgs = idex.mem_to_rgs;
        exmem_next.reg_wr     = idex.reg_wr;
    end

    // A flush only needs to kill the control bits; data fields simply keep their old value.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            exmem_reg <= '0;
            br_taken  <= 1'b0;
        end else if (flush) begin
            exmem_reg[EXMEM_CTRL_W-1:0] <= '0;
            br_taken                    <= 1'b0;
        end else if (!stall) begin
            exmem_reg <= exmem_next;
            br_taken  <= idex.brnch & alu_zero;
        end
    end

endmodule

// File: tb/tb_ex_stage.sv
// Directed self-checking bench for ex_stage; expectations adapt to whether EX_FWD_EN is defined.
module tb_ex_stage;
    import ex_stage_pkg::*;

    logic                clock;
    logic                reset;
    logic [IDEX_W-1:0]   idex_reg;
    logic                stall;
    logic                flush;
    logic                fw1_we;
    logic [4:0]          fw1_wa;
    logic [31:0]         fw1_dat;
    logic                fw2_we;
    logic [4:0]          fw2_wa;
    logic [31:0]         fw2_dat;
    logic [EXMEM_W-1:0]  exmem_reg;
    logic                br_taken;

    idex_t  ix;
    exmem_t em;
    exmem_t exp_w;
    int     n_cmp;
    int     n_err;

    assign idex_reg = ix;
    assign em       = exmem_t'(exmem_reg);

    ex_stage dut (
        .clock     (clock),
        .reset     (reset),
        .idex_reg  (idex_reg),
        .stall     (stall),
        .flush     (flush),
        .fw1_we    (fw1_we),
        .fw1_wa    (fw1_wa),
        .fw1_dat   (fw1_dat),
        .fw2_we    (fw2_we),
        .fw2_wa    (fw2_wa),
        .fw2_dat   (fw2_dat),
        .exmem_reg (exmem_reg),
        .br_taken  (br_taken)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [EXMEM_W-1:0] obs, input logic [EXMEM_W-1:0] expv);
        n_cmp++;
        assert (obs === expv) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, expv);
        end
        $display("check %-14s observed %h expected %h", tag, obs, expv);
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        logic [31:0] e_fw1, e_fw2, e_wdat;
`ifdef EX_FWD_EN
        e_fw1  = 32'd10;
        e_fw2  = 32'd20;
        e_wdat = 32'd10;
`else
        e_fw1  = 32'd1;
        e_fw2  = 32'd1;
        e_wdat = 32'd3;
`endif
        n_cmp = 0;
        n_err = 0;
        ix = '0;
        stall = 0; flush = 0;
        fw1_we = 0; fw1_wa = 0; fw1_dat = 0;
        fw2_we = 0; fw2_wa = 0; fw2_dat = 0;
        reset = 0;
        #2;
        chk("rst_exmem", exmem_reg, '0);
        chk("rst_br", {74'd0, br_taken}, '0);
        @(negedge clock);
        reset = 1;

        // ADD with immediate
        ix = '0; ix.rda = 5; ix.im_gen = 7; ix.alu_src = 1; ix.alu_op = ALU_ADD; ix.wa = 3; ix.reg_wr = 1;
        step();
        chk("add_res", em.alu_res, 12);
        chk("add_wa", em.wa, 3);
        chk("add_regwr", em.reg_wr, 1);
        chk("add_zero", em.zero, 0);

        // forwarding priority
        ix = '0; ix.ra = 4; ix.rda = 1; ix.alu_op = ALU_ADD;
        fw1_we = 1; fw1_wa = 4; fw1_dat = 10;
        fw2_we = 1; fw2_wa = 4; fw2_dat = 20;
        step();
        chk("fwd_fw1", em.alu_res, e_fw1);
        fw1_we = 0;
        step();
        chk("fwd_fw2", em.alu_res, e_fw2);
        fw1_we = 1; fw1_wa = 0; fw2_wa = 0; ix.ra = 0;
        step();
        chk("fwd_zreg", em.alu_res, 1);
        ix = '0; ix.rda = 2; ix.rb = 4; ix.rdb = 3; ix.alu_src = 1; ix.alu_op = ALU_ADD;
        fw1_we = 1; fw1_wa = 4; fw1_dat = 10; fw2_we = 0;
        step();
        chk("fwd_wdat", em.wdat, e_wdat);
        chk("fwd_imm_a", em.alu_res, 2);
        fw1_we = 0; fw1_wa = 0; fw1_dat = 0; fw2_wa = 0; fw2_dat = 0;

        // branch compare
        ix = '0; ix.ra = 1; ix.rb = 2; ix.rda = 9; ix.rdb = 9; ix.alu_op = ALU_SUB; ix.brnch = 1;
        step();
        chk("br_zero", em.zero, 1);
        chk("br_taken", br_taken, 1);
        ix.rdb = 8;
        step();
        chk("br_nt_res", em.alu_res, 1);
        chk("br_nt", br_taken, 0);

        // ALU operations through the immediate path
        ix = '0; ix.alu_src = 1; ix.rda = 32'h8000_0000; ix.im_gen = 4; ix.alu_op = ALU_SRA;
        step();
        chk("sra", em.alu_res, 32'hF800_0000);
        ix.alu_op = ALU_SRL;
        step();
        chk("srl", em.alu_res, 32'h0800_0000);
        ix.rda = 32'hFFFF_FFFF; ix.im_gen = 1; ix.alu_op = ALU_SLT;
        step();
        chk("slt_neg", em.alu_res, 1);
        ix.rda = 1; ix.im_gen = 32'hFFFF_FFFF;
        step();
        chk("slt_pos", em.alu_res, 0);
        ix.alu_op = 4'b1111; ix.rda = 32'h1234_5678;
        step();
        chk("op_bad", em.alu_res, 0);
        chk("op_bad_zero", em.zero, 1);
        ix.rda = 32'hF0F0_00FF; ix.im_gen = 32'h0FF0_0F0F; ix.alu_op = ALU_AND;
        step();
        chk("and", em.alu_res, 32'h00F0_000F);
        ix.alu_op = ALU_OR;
        step();
        chk("or", em.alu_res, 32'hFFF0_0FFF);
        ix.alu_op = ALU_XOR;
        step();
        chk("xor", em.alu_res, 32'hFF00_0FF0);
        ix.alu_op = ALU_NOR;
        step();
        chk("nor", em.alu_res, 32'h000F_F000);
        ix.alu_op = ALU_SLL;
        step();
        chk("sll", em.alu_res, 32'h007F_8000);
        ix.rda = 0; ix.im_gen = 1; ix.alu_op = ALU_SUB;
        step();
        chk("sub_wrap", em.alu_res, 32'hFFFF_FFFF);
        ix.rda = 32'hFFFF_FFFF; ix.alu_op = ALU_ADD;
        step();
        chk("add_wrap", em.alu_res, 0);
        chk("add_wrap_z", em.zero, 1);

        // stall holds a taken branch, then flush kills control bits
        ix = '0; ix.rda = 5; ix.im_gen = 5; ix.alu_src = 1; ix.alu_op = ALU_SUB;
        ix.brnch = 1; ix.wa = 7; ix.reg_wr = 1; ix.mem_rd = 1;
        exp_w = '0; exp_w.wa = 7; exp_w.zero = 1; exp_w.brnch = 1; exp_w.mem_rd = 1; exp_w.reg_wr = 1;
        step();
        chk("stall_load", exmem_reg, exp_w);
        stall = 1;
        for (int i = 0; i < 3; i++) begin
            ix.rda = 32'(100 + i); ix.wa = 5'(10 + i); ix.mem_wr = 1;
            step();
            chk("stall_hold", exmem_reg, exp_w);
            chk("stall_br", br_taken, 1);
        end
        flush = 1;
        step();
        chk("flush_ctrl", exmem_reg[5:0], 0);
        chk("flush_br", br_taken, 0);
        flush = 0; stall = 0;

        // asynchronous reset between edges
        ix = '0; ix.rda = 5; ix.im_gen = 7; ix.alu_src = 1; ix.alu_op = ALU_ADD; ix.wa = 3; ix.reg_wr = 1;
        step();
        chk("pre_areset", em.alu_res, 12);
        #2;
        reset = 0;
        #1;
        chk("areset_now", exmem_reg, '0);
        step();
        chk("areset_hold", exmem_reg, '0);
        @(negedge clock);
        reset = 1;
        step();
        exp_w = '0; exp_w.alu_res = 12; exp_w.wa = 3; exp_w.reg_wr = 1;
        chk("post_areset", exmem_reg, exp_w);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
